// File: rtl/obi_slave_sram_if.sv
// OBI request/response bundle between an OBI master and the SRAM slave.
// The master drives requests and response-ready; the slave drives grant and responses.
interface obi_slave_sram_if #(
    parameter int OBI_ADDR_WIDTH = 32,
    parameter int OBI_DATA_WIDTH = 32
);
    logic                      obi_slave_req;
    logic                      obi_slave_gnt;
    logic [OBI_ADDR_WIDTH-1:0] obi_slave_addr;
    logic                      obi_slave_we;
    logic [OBI_DATA_WIDTH-1:0] obi_slave_w_data;
    logic                      obi_slave_r_valid;
    logic                      obi_slave_r_ready;
    logic [OBI_DATA_WIDTH-1:0] obi_slave_r_data;

    modport master (
        output obi_slave_req, obi_slave_addr, obi_slave_we, obi_slave_w_data, obi_slave_r_ready,
        input  obi_slave_gnt, obi_slave_r_valid, obi_slave_r_data
    );

    modport slave (
        input  obi_slave_req, obi_slave_addr, obi_slave_we, obi_slave_w_data, obi_slave_r_ready,
        output obi_slave_gnt, obi_slave_r_valid, obi_slave_r_data
    );
endinterface

// File: rtl/obi_slave_sram.sv
// Word-addressed OBI SRAM slave: fixed-latency response pipeline feeding a show-ahead
// response FIFO, with credit-based grant so no response is ever dropped.
module obi_slave_sram #(
    parameter int                        OBI_ADDR_WIDTH = 32,
    parameter int                        OBI_DATA_WIDTH = 32,
    parameter int                        DEPTH          = 256,
    parameter logic [OBI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter int                        READ_LATENCY   = 2,
    parameter int                        RESP_DEPTH     = 4,
    parameter logic [OBI_DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic               obi_aclk,
    input  logic               obi_areset,
    obi_slave_sram_if.slave    bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PS = READ_LATENCY - 1;
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int OW = $clog2(RESP_DEPTH + READ_LATENCY + 1) + 1;
    localparam int AW = OBI_ADDR_WIDTH;
    localparam int DW = OBI_DATA_WIDTH;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [DW-1:0] mem_q [DEPTH];
    logic          xfer;
    logic          in_range;
    logic [IW-1:0] idx;
    logic [DW-1:0] resp_data;
    logic [AW:0]   addr_x;
    logic [AW:0]   lim_x;
    logic [OW-1:0] pipe_occ;
    logic [OW-1:0] outstanding;
    logic          push;
    logic [DW-1:0] push_data;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] last_q, last_d;
    logic [DW-1:0] fifo_q [RESP_DEPTH];
    logic          pop;

    // Decode and stage-0 response: the array is read before this edge's write lands.
    always_comb begin
        addr_x    = {1'b0, bus.obi_slave_addr};
        lim_x     = {1'b0, BASE_ADDR} + (AW + 1)'(4 * DEPTH);
        in_range  = (bus.obi_slave_addr >= BASE_ADDR) && (addr_x < lim_x);
        idx       = IW'((bus.obi_slave_addr - BASE_ADDR) >> 2);
        resp_data = '0;
        if (!bus.obi_slave_we) begin
            resp_data = in_range ? mem_q[idx] : ERR_DATA;
        end
    end

    assign outstanding       = OW'(count_q) + pipe_occ;
    assign bus.obi_slave_gnt = bus.obi_slave_req && !obi_areset &&
                               (outstanding < OW'(RESP_DEPTH));
    assign xfer              = bus.obi_slave_req && bus.obi_slave_gnt;

    always_ff @(posedge obi_aclk) begin
        if (xfer && bus.obi_slave_we && in_range) begin
            mem_q[idx] <= bus.obi_slave_w_data;
        end
    end

    // Latency pipeline: READ_LATENCY-1 register stages, then push into the FIFO.
    generate
        if (PS == 0) begin : g_nopipe
            assign push      = xfer;
            assign push_data = resp_data;
            assign pipe_occ  = '0;
        end else begin : g_pipe
            logic [PS-1:0] vld_q, vld_d;
            logic [DW-1:0] dat_q [PS];
            logic [DW-1:0] dat_d [PS];

            always_comb begin
                vld_d    = '0;
                vld_d[0] = xfer;
                dat_d[0] = resp_data;
                for (int i = 1; i < PS; i++) begin
                    vld_d[i] = vld_q[i-1];
                    dat_d[i] = dat_q[i-1];
                end
            end

            always_comb begin
                pipe_occ = '0;
                for (int i = 0; i < PS; i++) begin
                    pipe_occ = pipe_occ + OW'(vld_q[i]);
                end
            end

            always_ff @(posedge obi_aclk or posedge obi_areset) begin
                if (obi_areset) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
            end

            always_ff @(posedge obi_aclk) begin
                for (int i = 0; i < PS; i++) begin
                    dat_q[i] <= dat_d[i];
                end
            end

            assign push      = vld_q[PS-1];
            assign push_data = dat_q[PS-1];
        end
    endgenerate

    // Show-ahead response FIFO; r_data falls back to the last popped word when empty.
    assign bus.obi_slave_r_valid = (count_q != '0);
    assign bus.obi_slave_r_data  = bus.obi_slave_r_valid ? fifo_q[rd_ptr_q] : last_q;
    assign pop                   = bus.obi_slave_r_valid && bus.obi_slave_r_ready;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        last_d   = pop  ? fifo_q[rd_ptr_q]  : last_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge obi_aclk or posedge obi_areset) begin
        if (obi_areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge obi_aclk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: doc/obi_slave_sram.md
# obi_slave_sram

OBI slave memory that terminates the OBI master port of the SPI slave bridge, giving SPI-issued reads and writes a word-addressed SRAM target. It accepts requests on the address channel and returns exactly one in-order response per granted transaction through a configurable-latency read pipeline and a response FIFO. The FIFO honours `obi_master_r_ready` backpressure, and credit-based grant throttling ensures no response is ever dropped.

## Interface
- `OBI_ADDR_WIDTH`, 32, address width.
- `OBI_DATA_WIDTH`, 32, data width; must be 32.
- `DEPTH`, 256, number of 32-bit memory words; power of two, ≥2.
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
- `READ_LATENCY`, 2, grant-to-response cycles, 1..4.
- `RESP_DEPTH`, 4, maximum outstanding transactions (pipeline + FIFO), ≥1.
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned for out-of-range addresses.

Ports:
- `obi_aclk` input 1 — the single clock; all logic is on its rising edge.
- `obi_areset` input 1 — asynchronous, active-high reset.
- `obi_slave_req` input 1 — request valid.
- `obi_slave_gnt` output 1 — request accepted.
- `obi_slave_addr` input OBI_ADDR_WIDTH — byte address; bits [1:0] are ignored.
- `obi_slave_we` input 1 — 1 = write, 0 = read.
- `obi_slave_w_data` input OBI_DATA_WIDTH — write data.
- `obi_slave_r_valid` output 1 — response valid.
- `obi_slave_r_ready` input 1 — master accepts the response.
- `obi_slave_r_data` output OBI_DATA_WIDTH — read data; 0 for writes.

## Operation
- **Transfer.** A transaction transfers on a rising edge where `req && gnt`.
- **Grant.** `gnt` is combinational: `gnt = req && !obi_areset && (outstanding < RESP_DEPTH)`.
  - `outstanding` = pipeline occupancy + FIFO count, sampled at the current register state.
  - A same-cycle FIFO pop does not free a credit until the next cycle.
- **Address decode.** `in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*DEPTH)`. Word index = `(addr - BASE_ADDR) >> 2`, truncated to log2(DEPTH) bits.
- **Write.**
  - In range: the memory word is updated at the transfer edge.
  - Out of range: the write is discarded.
  - In both cases a response with `r_data = 0` is queued.
- **Read.**
  - The memory word is read at the transfer edge.
  - Out of range returns `ERR_DATA`.
  - A read in the cycle after a write to the same word returns the new data.
- **Pipeline.**
  - Responses (data plus a valid bit) pass through READ_LATENCY−1 register stages and are then written into the response FIFO.
  - The FIFO is show-ahead, RESP_DEPTH entries deep.
  - `r_valid` = FIFO non-empty; `r_data` = FIFO head.
  - The head pops on an edge where `r_valid && r_ready`.
- **Ordering.** Responses are strictly in grant order. Reads and writes share the same pipeline, so ordering is preserved across mixed traffic.
- **Full.** Grant throttling guarantees the FIFO never overflows, because the pipeline never holds more entries than free FIFO slots. The pipeline never stalls.
- **Empty.** `r_valid` = 0 and `r_data` holds its last value. `r_data` is don't-care when `r_valid` = 0, but it is 0 after reset.
- **Reset.**
  - Asynchronous assertion clears the pipeline valid bits, FIFO pointers, count and `r_data`.
  - Memory contents are not cleared.
  - Reset mid-transaction drops all in-flight responses; no response is emitted for them.

## Timing
- **Reset values:** `gnt` = 0, `r_valid` = 0, `r_data` = 0.
- **Latency.** A transfer at edge N with an empty FIFO gives `r_valid` = 1 in the cycle after edge N+READ_LATENCY−1, i.e. the master samples the response at edge N+READ_LATENCY.
  - READ_LATENCY = 1 means the response is available one edge after the grant.
- **Throughput.** With `r_ready` held at 1, back-to-back grants are sustained every cycle iff RESP_DEPTH ≥ READ_LATENCY + 1. Otherwise `gnt` drops periodically.
- **Backpressure.** With `r_ready` = 0, exactly RESP_DEPTH transactions are granted, then `gnt` stays 0. `gnt` returns one cycle after the first pop.
- **Stability.** `r_valid` and `r_data` remain stable while `r_valid && !r_ready`.
- **Simultaneous events.** A same-cycle FIFO push and pop leaves the count unchanged and preserves both entries in order.

## Test plan
- **Reset.** Assert `obi_areset` mid-cycle with `req` = 1 → `gnt`, `r_valid` and `r_data` are 0 immediately. After release, the first transfer responds at edge N+READ_LATENCY.
- **Write then read, READ_LATENCY = 2, BASE = 0.** Write 32'hCAFE_0001 to 0x10 at edge N, read 0x10 at edge N+1 → responses 0 at edge N+2 and 32'hCAFE_0001 at edge N+3.
- **Out of range, DEPTH = 256.** Write 32'h1234 to 0x400, then read 0x400 → `r_data` = 32'hDEAD_BEEF; word 0 is unchanged (read 0x0 returns its prior value).
- **Backpressure, RESP_DEPTH = 4.** Hold `r_ready` = 0 and issue 6 reads with `req` held → exactly 4 grants, `gnt` = 0 afterwards. Release `r_ready` → responses drain in order and the remaining 2 are granted.
- **Streaming, READ_LATENCY = 1, RESP_DEPTH = 2.** Hold `r_ready` = 1 and issue 16 consecutive reads of addresses 0..60 preloaded with their index → `gnt` = 1 every cycle, and `r_data` sequence 0..15 appears on consecutive cycles.
- **Random ready.** Toggle `r_ready` with 50% probability over 1000 mixed transactions → the scoreboard matches every response in order, and `outstanding` never exceeds RESP_DEPTH.
